data_mem_top: RTL

- Responder end of the data-memory interface driven by the memory-access pipeline stage.
- Accepts chip-select/write-enable/address/data requests and returns load data in the same cycle, so the existing combinational writeback mux is unchanged.
- Stores are posted into a small in-order write buffer that drains into a word array at a fixed write latency.
- Loads forward from the buffer on an address match.

---
 rtl/data_mem_top.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/data_mem_top.sv
// Data-memory responder: posted-store write buffer draining into a word array, with load forwarding.
// Optional performance counters are enabled by defining DMEM_PERF_CNT_EN.
module data_mem_top #(
    parameter int DEPTH    = 1024,
    parameter int AW       = $clog2(DEPTH),
    parameter int WB_DEPTH = 4,
    parameter int WR_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_cs,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dat_in,
    output logic [31:0] mem_dat_out,
    output logic        mem_rdy,
    output logic        wb_empty
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_ld_cnt,
    output logic [31:0] perf_st_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_fwd_cnt
`endif
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int LW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;
    localparam logic [LW-1:0] LAT_RELOAD = LW'(WR_LAT - 1);

    logic [31:0]   mem     [DEPTH];
    logic [AW-1:0] wb_addr [WB_DEPTH];
    logic [31:0]   wb_data [WB_DEPTH];

    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic [0:0]    state;
    logic [LW-1:0] lat_cnt;

    logic [AW-1:0] word_addr;
    logic          is_ld, is_st, enq, commit;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic          unused_addr_bits;

    assign word_addr        = mem_addr[AW+1:2];
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    assign is_ld    = mem_cs & ~mem_wen;
    assign is_st    = mem_cs & mem_wen;
    assign mem_rdy  = (count < (PW+1)'(WB_DEPTH));
    assign enq      = is_st & mem_rdy;
    assign commit   = (state == S_WRITE) && (lat_cnt == '0);
    assign wb_empty = (count == '0) && (state == S_IDLE);

    // Scan oldest to youngest so the last match wins; the draining entry stays
    // inside [head, head+count) until its commit edge, so it is still searched.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx = head + PW'(i);
            if (((PW+1)'(i) < count) && (wb_addr[idx] == word_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[idx];
            end
        end
    end

    always_comb begin
        mem_dat_out = '0;
        if (rst_n && is_ld)
            mem_dat_out = fwd_hit ? fwd_data : mem[word_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            state   <= S_IDLE;
            lat_cnt <= '0;
        end else begin
            if (enq)
                tail <= tail + 1'b1;
            if (commit)
                head <= head + 1'b1;
            count <= count + (PW+1)'(enq) - (PW+1)'(commit);
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state   <= S_WRITE;
                        lat_cnt <= LAT_RELOAD;
                    end
                end
                S_WRITE: begin
                    if (lat_cnt != '0)
                        lat_cnt <= lat_cnt - 1'b1;
                    else if (count > (PW+1)'(1))
                        lat_cnt <= LAT_RELOAD;
                    else
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Buffer payload and array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            wb_addr[tail] <= word_addr;
            wb_data[tail] <= mem_dat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (commit)
            mem[wb_addr[head]] <= wb_data[head];
    end

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ld_cnt    <= '0;
            perf_st_cnt    <= '0;
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (is_ld && (perf_ld_cnt != '1))
                perf_ld_cnt <= perf_ld_cnt + 1'b1;
            if (enq && (perf_st_cnt != '1))
                perf_st_cnt <= perf_st_cnt + 1'b1;
            if (is_st && !mem_rdy && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (is_ld && fwd_hit && (perf_fwd_cnt != '1))
                perf_fwd_cnt <= perf_fwd_cnt + 1'b1;
        end
    end
`endif

endmodule
